// File: rtl/ex_div_ctrl_pkg.sv
// ex_div_ctrl_pkg: divide-op bit indices, FSM encoding and nominal divider latency for ex_div_ctrl
package ex_div_ctrl_pkg;
  localparam int DIV_W  = 0;
  localparam int MOD_W  = 1;
  localparam int DIV_WU = 2;
  localparam int MOD_WU = 3;
  localparam int DIV_CYCLES = 34;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;
endpackage

// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: EX-stage sequencer for the multicycle divider (operand capture, stall, result select, flush drain)
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = ex_div_ctrl_pkg::DIV_CYCLES,
  parameter int WDOG_MAX   = 40
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es_valid,
  input  logic [3:0]          es_div_op,
  input  logic [DATA_W-1:0]   es_src1,
  input  logic [DATA_W-1:0]   es_src2,
  input  logic                es_flush,
  input  logic                ms_allowin,
  output logic                div_en,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_num,
  output logic [DATA_W-1:0]   div_den,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_complete,
  output logic                es_div_stall,
  output logic                div_out_valid,
  output logic [DATA_W-1:0]   div_out_value,
  output logic                div_timeout
);
  localparam int CNT_W = $clog2(WDOG_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_MAX);
  if (DATA_W != 32 || WDOG_MAX <= DIV_CYCLES) begin : g_bad_cfg
    $error("ex_div_ctrl: DATA_W must be 32 and WDOG_MAX must exceed DIV_CYCLES");
  end
  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] num_q, num_d, den_q, den_d, value_q, value_d;
  logic              signed_q, signed_d, is_mod_q, is_mod_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              accept, waiting, drain_entry;
  assign accept      = state_q == ST_IDLE && es_valid && |es_div_op && !es_flush;
  assign waiting     = state_q == ST_BUSY || state_q == ST_DRAIN;
  assign drain_entry = state_q == ST_BUSY && es_flush && !div_complete;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      den_q     <= '0;
      value_q   <= '0;
      signed_q  <= 1'b0;
      is_mod_q  <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      den_q     <= den_d;
      value_q   <= value_d;
      signed_q  <= signed_d;
      is_mod_q  <= is_mod_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end
  // A flush coinciding with completion has nothing left to drain, so it goes straight to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = accept ? ST_BUSY : ST_IDLE;
      ST_BUSY:  state_d = div_complete ? (es_flush ? ST_IDLE : ST_DONE) : (es_flush ? ST_DRAIN : ST_BUSY);
      ST_DONE:  state_d = (ms_allowin || es_flush) ? ST_IDLE : ST_DONE;
      ST_DRAIN: state_d = div_complete ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    num_d     = accept ? es_src1 : num_q;
    den_d     = accept ? es_src2 : den_q;
    signed_d  = accept ? (es_div_op[DIV_W] | es_div_op[MOD_W]) : signed_q;
    is_mod_d  = accept ? (es_div_op[MOD_W] | es_div_op[MOD_WU]) : is_mod_q;
    value_d   = (state_q == ST_BUSY && div_complete && !es_flush)
              ? (is_mod_q ? div_result[DATA_W-1:0] : div_result[2*DATA_W-1:DATA_W]) : value_q;
    wdog_d    = (accept || drain_entry) ? '0
              : (waiting && wdog_q != WDOG_LIM) ? wdog_q + 1'b1 : wdog_q;
    timeout_d = timeout_q | (waiting && wdog_q == WDOG_LIM);
  end
  // div_en stays up through DRAIN: dropping it mid-operation would freeze the divider's counter.
  always_comb begin
    div_en        = waiting;
    div_out_valid = state_q == ST_DONE;
    es_div_stall  = es_valid && |es_div_op && (state_q == ST_IDLE || state_q == ST_BUSY);
  end
  assign div_signed    = signed_q;
  assign div_num       = num_q;
  assign div_den       = den_q;
  assign div_out_value = value_q;
  assign div_timeout   = timeout_q;
endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: vector table plus flush/back-pressure/reset/watchdog sequences against a divider stub
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;
  localparam int DC = 34;
  localparam logic [3:0] OP_DIV_W  = 4'b1 << DIV_W;
  localparam logic [3:0] OP_MOD_W  = 4'b1 << MOD_W;
  localparam logic [3:0] OP_DIV_WU = 4'b1 << DIV_WU;
  localparam logic [3:0] OP_MOD_WU = 4'b1 << MOD_WU;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          hold;
  } vec_t;
  logic clk = 0, resetn = 0, es_valid = 0, es_flush = 0, ms_allowin = 1;
  logic [3:0]  es_div_op = '0;
  logic [31:0] es_src1 = '0, es_src2 = '0;
  logic div_en, div_signed, div_complete, es_div_stall, div_out_valid, div_timeout;
  logic [31:0] div_num, div_den, div_out_value;
  logic [63:0] div_result;
  int n_cmp = 0, n_err = 0, cyc = 0, en_cnt = 0, valid_cnt = 0, stub_cnt = 0;
  logic stub_hang = 0;
  logic [31:0] sb[$];
  vec_t vt[7];
  always #5 clk = ~clk;
  ex_div_ctrl dut (
    .clk(clk), .resetn(resetn), .es_valid(es_valid), .es_div_op(es_div_op),
    .es_src1(es_src1), .es_src2(es_src2), .es_flush(es_flush), .ms_allowin(ms_allowin),
    .div_en(div_en), .div_signed(div_signed), .div_num(div_num), .div_den(div_den),
    .div_result(div_result), .div_complete(div_complete), .es_div_stall(es_div_stall),
    .div_out_valid(div_out_valid), .div_out_value(div_out_value), .div_timeout(div_timeout)
  );
  always @(posedge clk) cyc <= cyc + 1;
  // Divider stub: completes on the DC-th consecutive div_en cycle, counter clears when div_en drops.
  always @(posedge clk) stub_cnt <= (!resetn || !div_en) ? 0 : stub_cnt + 1;
  assign div_complete = div_en && !stub_hang && stub_cnt == DC - 1;
  function automatic logic [63:0] ref_div(logic s, logic [31:0] x, logic [31:0] y);
    if (y == 0) return {32'hFFFFFFFF, x};
    return s ? {32'($signed(x) / $signed(y)), 32'($signed(x) % $signed(y))} : {x / y, x % y};
  endfunction
  assign div_result = ref_div(div_signed, div_num, div_den);
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (div_en) en_cnt++;
    if (div_out_valid) valid_cnt++;
    if (div_out_valid && ms_allowin) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("result", div_out_value, sb.pop_front());
    end
  end
  task automatic check_zero(string tag);
    chk({tag, "_div_en"}, div_en, 0);
    chk({tag, "_signed"}, div_signed, 0);
    chk({tag, "_num"}, div_num, 0);
    chk({tag, "_den"}, div_den, 0);
    chk({tag, "_valid"}, div_out_valid, 0);
    chk({tag, "_value"}, div_out_value, 0);
    chk({tag, "_stall"}, es_div_stall, 0);
    chk({tag, "_timeout"}, div_timeout, 0);
  endtask
  // Called just after a rising edge; returns just after the rising edge following the hand-off to MEM.
  task automatic do_div(logic [3:0] op, logic [31:0] x, logic [31:0] y, logic [31:0] exp, int hold);
    int t0, e0, lat;
    logic prev_stall;
    es_valid = 1; es_div_op = op; es_src1 = x; es_src2 = y; ms_allowin = (hold == 0);
    sb.push_back(exp);
    t0 = cyc; e0 = en_cnt; lat = -1; prev_stall = 0;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      @(negedge clk);
      if (div_out_valid) lat = cyc - t0;
      else prev_stall = es_div_stall;
    end
    chk("latency", lat, DC + 1);
    chk("stall_before_done", prev_stall, 1);
    chk("stall_in_done", es_div_stall, 0);
    chk("div_en_cycles", en_cnt - e0, DC);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", div_out_valid, 1);
      chk("hold_value", div_out_value, exp);
      @(posedge clk); #1;
      if (i == hold - 1) ms_allowin = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    es_valid = 0; es_div_op = '0;
    if (hold > 0) begin
      @(negedge clk);
      chk("exit_idle", div_out_valid, 0);
      @(posedge clk); #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int t0, e0, v0;
    vt = '{
      '{OP_DIV_W,  32'hFFFFFFF9, 32'd2,  32'hFFFFFFFD, 0},
      '{OP_MOD_W,  32'hFFFFFFF9, 32'd2,  32'hFFFFFFFF, 0},
      '{OP_DIV_WU, 32'hFFFFFFF9, 32'd2,  32'h7FFFFFFC, 0},
      '{OP_MOD_WU, 32'd100,      32'd7,  32'h00000002, 0},
      '{OP_DIV_W,  32'd20,       32'd4,  32'h00000005, 0},
      '{OP_MOD_W,  32'd20,       32'd6,  32'h00000002, 0},
      '{OP_DIV_WU, 32'h00001234, 32'h10, 32'h00000123, 5}
    };
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    resetn = 1;
    foreach (vt[i]) do_div(vt[i].op, vt[i].x, vt[i].y, vt[i].exp, vt[i].hold);
    // flush at T+10, then a second flush while draining
    es_valid = 1; es_div_op = OP_DIV_W; es_src1 = 32'd100; es_src2 = 32'd7;
    t0 = cyc; e0 = en_cnt; v0 = valid_cnt;
    repeat (10) begin @(posedge clk); #1; end
    es_flush = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_in_drain", es_div_stall, 0);
    chk("en_in_drain", div_en, 1);
    @(posedge clk); #1;
    es_flush = 0; es_valid = 0; es_div_op = '0;
    for (int i = 0; i < 60 && div_en; i++) @(negedge clk);
    chk("drain_en_cycles", en_cnt - e0, DC);
    chk("drain_no_valid", valid_cnt - v0, 0);
    chk("drain_time", cyc - t0, DC + 1);
    @(posedge clk); #1;
    do_div(OP_DIV_W, 32'd9, 32'd3, 32'd3, 0);
    // reset for one cycle at T+15
    es_valid = 1; es_div_op = OP_DIV_W; es_src1 = 32'd50; es_src2 = 32'd5;
    repeat (15) begin @(posedge clk); #1; end
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1; es_valid = 0; es_div_op = '0;
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    do_div(OP_DIV_W, 32'd8, 32'd2, 32'd4, 0);
    chk("timeout_clear", div_timeout, 0);
    // watchdog: divider never completes
    stub_hang = 1;
    es_valid = 1; es_div_op = OP_DIV_WU; es_src1 = 32'd1; es_src2 = 32'd1;
    @(posedge clk); #1;
    es_valid = 0; es_div_op = '0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("wdog_before", div_timeout, 0);
    @(negedge clk);
    chk("wdog_set", div_timeout, 1);
    chk("wdog_still_busy", div_en, 1);
    repeat (5) @(negedge clk);
    chk("wdog_sticky", div_timeout, 1);
    @(posedge clk); #1;
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1; stub_hang = 0;
    @(negedge clk);
    chk("wdog_reset", div_timeout, 0);
    chk("wdog_reset_en", div_en, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
